// File: rtl/prog_counter_divider.sv
// Programmable up/down counter and clock-enable divider.
// Counts 0..M-1 (M=0 selects the full 2^WIDTH range), with wrap or one-shot
// behaviour, a terminal-count pulse and a divide-by-2M toggle output.
// All outputs come straight from flops, so they are safe to use as clock enables.

module prog_counter_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] mod_i,
  input  logic             dir_i,
  input  logic             oneshot_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             div_o,
  output logic             done_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             div_q, div_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] term;
  logic             term_event;

  // Highest legal count and the value that ends a pass in the current direction.
  always_comb begin
    last = (mod_i == '0) ? '1 : (mod_i - 1'b1);
    term = dir_i ? last : '0;
  end

  // Next-state logic: clear beats load beats enable; a count left above LAST
  // (by a load or a shrinking modulus) is pulled back into range.
  always_comb begin
    q_d        = q_q;
    tc_d       = 1'b0;
    div_d      = div_q;
    done_d     = done_q;
    term_event = 1'b0;

    if (clr_i) begin
      q_d    = '0;
      div_d  = 1'b0;
      done_d = 1'b0;
    end else if (load_i) begin
      q_d    = load_val_i;
      done_d = 1'b0;
    end else if (en_i && !(done_q && oneshot_i)) begin
      // Reaching here with done set means one-shot was dropped: release it.
      done_d = 1'b0;
      if (dir_i) begin
        if ((q_q == term) || (q_q > last)) begin
          term_event = 1'b1;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (q_q == '0) begin
          term_event = 1'b1;
        end else if (q_q > last) begin
          q_d = last;
        end else begin
          q_d = q_q - 1'b1;
        end
      end

      if (term_event) begin
        tc_d  = 1'b1;
        div_d = ~div_q;
        if (oneshot_i) begin
          done_d = 1'b1;
        end else begin
          q_d = dir_i ? '0 : last;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q    <= '0;
      tc_q   <= 1'b0;
      div_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      tc_q   <= tc_d;
      div_q  <= div_d;
      done_q <= done_d;
    end
  end

  assign q_o    = q_q;
  assign tc_o   = tc_q;
  assign div_o  = div_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_prog_counter_divider.sv
// Directed bench for prog_counter_divider with a scoreboard queue.
module tb_prog_counter_divider;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         en_i = 1'b0;
  logic         clr_i = 1'b0;
  logic         load_i = 1'b0;
  logic [W-1:0] load_val_i = '0;
  logic [W-1:0] mod_i = '0;
  logic         dir_i = 1'b1;
  logic         oneshot_i = 1'b0;
  logic [W-1:0] q_o;
  logic         tc_o;
  logic         div_o;
  logic         done_o;

  typedef struct {
    string        tag;
    logic [W+2:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic ediv = 1'b0;

  prog_counter_divider #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .mod_i      (mod_i),
    .dir_i      (dir_i),
    .oneshot_i  (oneshot_i),
    .q_o        (q_o),
    .tc_o       (tc_o),
    .div_o      (div_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_now(input string tag, input logic [W+2:0] exp);
    logic [W+2:0] got;
    got = {q_o, tc_o, div_o, done_o};
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got q/tc/div/done=%h/%b/%b/%b exp=%h/%b/%b/%b", tag,
             got[W+2:3], got[2], got[1], got[0], exp[W+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Inputs are already driven; push the expectation, clock once, compare.
  task automatic step(input string tag, input logic [W-1:0] eq, input logic etc,
                      input logic edone);
    exp_t e;
    e.tag = tag;
    e.v   = {eq, etc, ediv, edone};
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check_now(e.tag, e.v);
  endtask

  task automatic idle_inputs();
    en_i = 1'b0; clr_i = 1'b0; load_i = 1'b0; load_val_i = '0;
  endtask

  initial begin
    // Reset state
    #12;
    check_now("reset", '0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    // Up wrap, M=10
    mod_i = 8'd10; dir_i = 1'b1; oneshot_i = 1'b0; en_i = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      ediv = ((i / 10) % 2) == 1;
      step("up_wrap", W'(i % 10), (i % 10) == 0, 1'b0);
    end

    // Asynchronous reset at q=5, checked before any clock edge
    #2;
    rst_n_i = 1'b0;
    #1;
    ediv = 1'b0;
    check_now("async_rst", '0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    // Down, full range
    mod_i = 8'd0; dir_i = 1'b0; en_i = 1'b1;
    ediv = 1'b1;
    step("down_first", 8'd255, 1'b1, 1'b0);
    for (int k = 1; k <= 255; k++) begin
      step("down_run", W'(255 - k), 1'b0, 1'b0);
    end
    ediv = 1'b0;
    step("down_rewrap", 8'd255, 1'b1, 1'b0);

    // Priority: clear wins over load and enable
    clr_i = 1'b1; load_i = 1'b1; load_val_i = 8'd77; en_i = 1'b1;
    step("prio_clr", 8'd0, 1'b0, 1'b0);
    idle_inputs();

    // One-shot, M=4 up
    mod_i = 8'd4; dir_i = 1'b1; oneshot_i = 1'b1; en_i = 1'b1;
    step("os_1", 8'd1, 1'b0, 1'b0);
    step("os_2", 8'd2, 1'b0, 1'b0);
    step("os_3", 8'd3, 1'b0, 1'b0);
    ediv = 1'b1;
    step("os_term", 8'd3, 1'b1, 1'b1);
    step("os_hold1", 8'd3, 1'b0, 1'b1);
    step("os_hold2", 8'd3, 1'b0, 1'b1);
    en_i = 1'b0;
    step("os_idle", 8'd3, 1'b0, 1'b1);
    // Dropping one-shot releases done and wraps
    oneshot_i = 1'b0; en_i = 1'b1;
    ediv = 1'b0;
    step("os_release", 8'd0, 1'b1, 1'b0);
    oneshot_i = 1'b1;
    step("os_r1", 8'd1, 1'b0, 1'b0);
    step("os_r2", 8'd2, 1'b0, 1'b0);
    step("os_r3", 8'd3, 1'b0, 1'b0);
    ediv = 1'b1;
    step("os_rterm", 8'd3, 1'b1, 1'b1);
    en_i = 1'b0; load_i = 1'b1; load_val_i = 8'd0;
    step("os_load0", 8'd0, 1'b0, 1'b0);
    idle_inputs(); en_i = 1'b1;
    step("os_restart", 8'd1, 1'b0, 1'b0);

    // Out of range after a load, M=10
    idle_inputs(); oneshot_i = 1'b0; clr_i = 1'b1;
    ediv = 1'b0;
    step("clr_div", 8'd0, 1'b0, 1'b0);
    idle_inputs(); mod_i = 8'd10; dir_i = 1'b1;
    load_i = 1'b1; load_val_i = 8'd200;
    step("load200", 8'd200, 1'b0, 1'b0);
    idle_inputs(); en_i = 1'b1;
    ediv = 1'b1;
    step("oor_up", 8'd0, 1'b1, 1'b0);
    idle_inputs(); load_i = 1'b1; load_val_i = 8'd200; en_i = 1'b1;
    step("load200b", 8'd200, 1'b0, 1'b0);
    idle_inputs(); dir_i = 1'b0; en_i = 1'b1;
    step("oor_down", 8'd9, 1'b0, 1'b0);
    step("down_8", 8'd8, 1'b0, 1'b0);

    // Modulus change 10 -> 5 at q=7
    idle_inputs(); clr_i = 1'b1;
    ediv = 1'b0;
    step("clr2", 8'd0, 1'b0, 1'b0);
    idle_inputs(); dir_i = 1'b1; mod_i = 8'd10; en_i = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step("pre_mod", W'(i), 1'b0, 1'b0);
    end
    mod_i = 8'd5;
    ediv = 1'b1;
    step("mod_shrink", 8'd0, 1'b1, 1'b0);

    // M=1 wrap: tc held, div toggles every enabled cycle
    mod_i = 8'd1;
    for (int i = 0; i < 4; i++) begin
      ediv = ~ediv;
      step("m1", 8'd0, 1'b1, 1'b0);
    end
    en_i = 1'b0;
    step("m1_idle", 8'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
